apu_resp_router: RTL and testbench
==================================

Name: apu_resp_router

Overview:
- Return path of a shared APU unit in the APU cluster.
- The cluster arbiter issues an operation to a fixed-latency shared FP/DSP unit and tags it with the originating core ID. This block delays that tag in step with the unit pipeline and captures the unit's result and flags.
- Results are buffered in order and delivered to the originating core through a per-core valid/ready handshake.
- Credit accounting guarantees that a non-stallable unit pipeline never produces a result with nowhere to store it.

Parameters:
- NCORES, 4: number of cores sharing the unit.
- LAT, 1: unit pipeline depth in cycles. Set from the package pipe-reg constant, e.g. C_ADDSUB_PIPE_REGS. Must be ≥1.
- WRESULT, 32: result width (FP_WIDTH).
- NUSFLAGS, 5: upstream flag width (NUSFLAGS_ADDSUB).
- DEPTH, LAT+2: response FIFO entries. Must be ≥2.
- Derived: CIDW = max(1, $clog2(NCORES)).

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- req_valid_i, in, 1: arbiter issues an op to the unit this cycle.
- req_core_i, in, CIDW: originating core of the issued op.
- req_ready_o, out, 1: router can accept an op this cycle.
- unit_valid_i, in, 1: unit result valid. Arrives exactly LAT cycles after acceptance.
- unit_result_i, in, WRESULT: unit result.
- unit_flags_i, in, NUSFLAGS: unit flags.
- core_valid_o, out, NCORES: one-hot response valid.
- core_result_o, out, WRESULT: shared response data bus.
- core_flags_o, out, NUSFLAGS: shared response flags bus.
- core_ready_i, in, NCORES: per-core response ready.
- err_o, out, 1: sticky protocol-mismatch flag.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - All tag stages invalid; inflight_cnt=0; FIFO empty.
  - core_valid_o=0; core_result_o=0; core_flags_o=0; err_o=0.
  - req_ready_o is forced 0 while rst=1.
- Accept: acc = req_valid_i & req_ready_o.
- Ready rule: req_ready_o = !rst & ((inflight_cnt + fifo_cnt) < DEPTH). It depends on registers only and never on core_ready_i.
- Tag pipe:
  - LAT-stage shift register of {valid, core}. Stage0 loads {acc, req_core_i} each cycle.
  - The last stage is tag_out.
  - It shifts every cycle and never stalls.
- inflight_cnt:
  - +1 on acc; −1 when tag_out.valid.
  - Simultaneous increment and decrement leaves it unchanged.
  - Width is $clog2(DEPTH+1).
- Push: push when tag_out.valid. The entry is {tag_out.core, unit_result_i, unit_flags_i}.
  - Credits guarantee the FIFO is never full at push time. Asserting full-at-push is a bench check.
- Mismatch:
  - Condition: tag_out.valid != unit_valid_i.
  - Action: set err_o, which stays set until rst.
  - If unit_valid_i arrives without a tag, the result is dropped.
  - If a tag arrives without unit_valid_i, an entry is still pushed carrying the bus data, so credits stay consistent.
- Output:
  - FIFO non-empty → core_valid_o = 1 << head.core, and core_result_o/core_flags_o = head data.
  - Empty → core_valid_o=0 and the data buses are held at their last value. The data buses are don't-care when core_valid_o=0.
  - Pop when core_ready_i[head.core]. Ready bits of other cores are ignored.
  - A valid stays asserted, with stable data, until popped.
- Ordering and throughput:
  - Strict in-order delivery. A stalled core blocks responses for all cores (head-of-line blocking is accepted).
  - Push and pop in the same cycle are both performed; the count is unchanged.
  - Pop on empty is impossible because valid=0.
- Latency: acceptance at cycle t → core_valid_o at t+LAT+1 when the FIFO is empty.
- Steady state: with cores ready, DEPTH=LAT+2 sustains 1 op/cycle (inflight LAT + fifo ≤1 < DEPTH).
- FIFO pointers: wrap modulo DEPTH. DEPTH need not be a power of two; use an explicit count.
- Reset mid-operation: in-flight tags and buffered results are discarded. A late unit_valid_i after reset counts as a mismatch (sets err_o).

Decomposition:
- Package additions to apu_cluster_package:
  - C_APU_NCORES (default 4).
  - Per-unit LAT mapping via the existing C_*_PIPE_REGS.
  - C_RESP_FIFO_EXTRA=2.
- Entry struct: a packed struct {core, result, flags} is declared locally, since its widths are parameter-dependent.
- Sub-module: apu_resp_fifo. Parameterised depth/width, in-order, count output, synchronous active-high reset, simultaneous push/pop supported.

Test Plan:
1. Reset: hold rst=1 for 2 cycles → req_ready_o=0, core_valid_o=0 and err_o=0 throughout; req_ready_o=1 in the first cycle after release.
2. Single op: LAT=1; accept core 2 at cycle 0; unit_valid_i=1 with result 32'h3F800000 and flags 5'b00001 at cycle 1 → cycle 2: core_valid_o=4'b0100 with that data. core_ready_i=4'b0100 → valid clears at cycle 3.
3. Backpressure: core_ready_i=0; issue ops for core 1 then core 3 → req_ready_o falls once inflight+fifo=3. Raise core_ready_i[3] only → nothing pops. Raise core_ready_i[1] → core 1 is delivered, then core 3 next cycle.
4. Streaming: all ready; 8 back-to-back ops for cores 0,1,2,3,0,1,2,3 → req_ready_o never drops. Results appear on consecutive cycles 2..9 with matching one-hot valids.
5. Mismatch: unit_valid_i=1 with no tag outstanding → err_o=1 next cycle, no push, stays 1 until rst.
6. Reset mid-op: 2 ops in flight plus 1 buffered, assert rst → core_valid_o=0 and no spurious response afterwards; inflight_cnt=0 so req_ready_o=1 after release.

Source files
------------

// File: rtl/apu_resp_router_pkg.sv
// Cluster-level constants for the shared APU return path: core count, unit pipe depths,
// response FIFO slack, plus small helpers for deriving widths and per-unit latency.
package apu_resp_router_pkg;

  localparam int C_APU_NCORES       = 4;
  localparam int C_FP_WIDTH         = 32;
  localparam int C_NUSFLAGS_ADDSUB  = 5;

  localparam int C_ADDSUB_PIPE_REGS = 1;
  localparam int C_MULT_PIPE_REGS   = 2;
  localparam int C_MAC_PIPE_REGS    = 3;

  // Slots beyond the unit latency so a registered pop never throttles a full-rate stream.
  localparam int C_RESP_FIFO_EXTRA  = 2;

  typedef enum logic [1:0] {
    APU_ADDSUB = 2'd0,
    APU_MULT   = 2'd1,
    APU_MAC    = 2'd2
  } apu_unit_e;

  function automatic int unit_lat(input apu_unit_e unit);
    case (unit)
      APU_MULT: return C_MULT_PIPE_REGS;
      APU_MAC:  return C_MAC_PIPE_REGS;
      default:  return C_ADDSUB_PIPE_REGS;
    endcase
  endfunction

  function automatic int cid_width(input int ncores);
    return (ncores > 1) ? $clog2(ncores) : 1;
  endfunction

endpackage

// File: rtl/apu_resp_fifo.sv
// In-order response buffer with explicit occupancy count; depth need not be a power of two.
// Zero-latency head view; simultaneous push and pop both take effect, push when full is not guarded.
module apu_resp_fifo
  import apu_resp_router_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign count    = cnt;
  assign empty    = (cnt == '0);

endmodule

// File: rtl/apu_resp_router.sv
// Shared-APU return path: delays the issuing core's tag alongside the unit, buffers results in order.
// Latency LAT+1 to core_valid_o; credit-limited issue so the non-stallable unit always has a free slot.
module apu_resp_router
  import apu_resp_router_pkg::*;
#(
  parameter int NCORES   = C_APU_NCORES,
  parameter int LAT      = C_ADDSUB_PIPE_REGS,
  parameter int WRESULT  = C_FP_WIDTH,
  parameter int NUSFLAGS = C_NUSFLAGS_ADDSUB,
  parameter int DEPTH    = LAT + C_RESP_FIFO_EXTRA
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid_i,
  input  logic [cid_width(NCORES)-1:0]      req_core_i,
  output logic                              req_ready_o,
  input  logic                              unit_valid_i,
  input  logic [WRESULT-1:0]                unit_result_i,
  input  logic [NUSFLAGS-1:0]               unit_flags_i,
  output logic [NCORES-1:0]                 core_valid_o,
  output logic [WRESULT-1:0]                core_result_o,
  output logic [NUSFLAGS-1:0]               core_flags_o,
  input  logic [NCORES-1:0]                 core_ready_i,
  output logic                              err_o
);

  localparam int CIDW = cid_width(NCORES);
  localparam int IW   = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [CIDW-1:0]     core;
    logic [WRESULT-1:0]  result;
    logic [NUSFLAGS-1:0] flags;
  } entry_t;

  localparam int EW = $bits(entry_t);

  logic              acc;
  logic [LAT-1:0]    tag_vld;
  logic [CIDW-1:0]   tag_core [LAT];
  logic              tag_out_vld;
  logic [CIDW-1:0]   tag_out_core;
  logic [IW-1:0]     inflight_cnt;
  logic [IW-1:0]     fifo_cnt;
  logic [IW:0]       occupancy;
  logic              fifo_empty;
  logic              pop;
  logic              err_q;
  entry_t            push_ent;
  entry_t            head;
  entry_t            hold_q;

  // Credits cover both ops still in the unit and results waiting in the buffer.
  assign occupancy   = {1'b0, inflight_cnt} + {1'b0, fifo_cnt};
  assign req_ready_o = !rst && (occupancy < (IW+1)'(DEPTH));
  assign acc         = req_valid_i && req_ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_core[i] <= '0;
      end
    end else begin
      tag_vld[0]  <= acc;
      tag_core[0] <= req_core_i;
      for (int i = 1; i < LAT; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_core[i] <= tag_core[i-1];
      end
    end
  end

  assign tag_out_vld  = tag_vld[LAT-1];
  assign tag_out_core = tag_core[LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_cnt <= '0;
    end else begin
      case ({acc, tag_out_vld})
        2'b10:   inflight_cnt <= inflight_cnt + 1'b1;
        2'b01:   inflight_cnt <= inflight_cnt - 1'b1;
        default: inflight_cnt <= inflight_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (tag_out_vld != unit_valid_i) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

  // A tag without unit data still pushes so the credit count stays balanced.
  always_comb begin
    push_ent        = '0;
    push_ent.core   = tag_out_core;
    push_ent.result = unit_result_i;
    push_ent.flags  = unit_flags_i;
  end

  apu_resp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_out_vld),
    .push_data (push_ent),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_cnt),
    .empty     (fifo_empty)
  );

  // Only the head's own ready bit matters: strict order, head-of-line blocking accepted.
  always_comb begin
    core_valid_o = '0;
    pop          = 1'b0;
    if (!rst && !fifo_empty) begin
      core_valid_o[head.core] = 1'b1;
      pop                     = core_ready_i[head.core];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else if (!fifo_empty) begin
      hold_q <= head;
    end
  end

  assign core_result_o = fifo_empty ? hold_q.result : head.result;
  assign core_flags_o  = fifo_empty ? hold_q.flags  : head.flags;

endmodule

// File: tb/tb_apu_resp_router.sv
// Directed plus random stimulus for apu_resp_router, checked against a queue-based response model.
module tb_apu_resp_router;

  localparam int NCORES = 4;
  localparam int LAT    = 1;
  localparam int DEPTH  = LAT + 2;

  typedef struct packed {
    logic [1:0]  core;
    logic [31:0] res;
    logic [4:0]  fl;
  } ent_t;

  typedef struct {
    int   due;
    ent_t e;
  } op_t;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic [1:0]  req_core_i;
  logic        req_ready_o;
  logic        unit_valid_i;
  logic [31:0] unit_result_i;
  logic [4:0]  unit_flags_i;
  logic [3:0]  core_valid_o;
  logic [31:0] core_result_o;
  logic [4:0]  core_flags_o;
  logic [3:0]  core_ready_i;
  logic        err_o;

  apu_resp_router #(
    .NCORES   (NCORES),
    .LAT      (LAT),
    .WRESULT  (32),
    .NUSFLAGS (5),
    .DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .req_core_i    (req_core_i),
    .req_ready_o   (req_ready_o),
    .unit_valid_i  (unit_valid_i),
    .unit_result_i (unit_result_i),
    .unit_flags_i  (unit_flags_i),
    .core_valid_o  (core_valid_o),
    .core_result_o (core_result_o),
    .core_flags_o  (core_flags_o),
    .core_ready_i  (core_ready_i),
    .err_o         (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   ntests = 0;
  int   nfail  = 0;
  int   cyc    = 0;
  int   ndelivered = 0;
  bit   exp_err = 1'b0;
  bit   inject  = 1'b0;
  bit   fix_en  = 1'b0;
  logic [31:0] fix_res;
  logic [4:0]  fix_fl;
  ent_t exp_q[$];
  op_t  unit_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: act as the unit, check outputs at negedge, advance the model at posedge.
  task automatic cycle();
    bit         due;
    bit         exp_ready;
    bit         acc;
    bit         pop;
    logic [3:0] exp_valid;
    op_t        o;

    due = (unit_q.size() > 0) && (unit_q[0].due == cyc);
    if (due) begin
      unit_valid_i  = 1'b1;
      unit_result_i = unit_q[0].e.res;
      unit_flags_i  = unit_q[0].e.fl;
    end else begin
      unit_valid_i  = inject;
      unit_result_i = $urandom;
      unit_flags_i  = 5'($urandom);
    end

    exp_ready = !rst && ((unit_q.size() + exp_q.size()) < DEPTH);
    exp_valid = (!rst && exp_q.size() > 0) ? (4'b0001 << exp_q[0].core) : 4'b0000;

    @(negedge clk);
    chk("req_ready", 64'(req_ready_o), 64'(exp_ready));
    chk("core_valid", 64'(core_valid_o), 64'(exp_valid));
    chk("err", 64'(err_o), 64'(exp_err));
    if (exp_valid != 4'b0000) begin
      chk("core_result", 64'(core_result_o), 64'(exp_q[0].res));
      chk("core_flags", 64'(core_flags_o), 64'(exp_q[0].fl));
    end

    acc = req_valid_i && exp_ready;
    pop = (exp_valid != 4'b0000) && core_ready_i[exp_q[0].core];

    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      unit_q.delete();
      exp_err = 1'b0;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        ndelivered++;
      end
      if (due) begin
        o = unit_q.pop_front();
        exp_q.push_back(o.e);
      end else if (inject) begin
        exp_err = 1'b1;
      end
      if (acc) begin
        o.due    = cyc + LAT;
        o.e.core = req_core_i;
        o.e.res  = fix_en ? fix_res : $urandom;
        o.e.fl   = fix_en ? fix_fl  : 5'($urandom);
        unit_q.push_back(o);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
    end
  endtask

  initial begin
    int base;
    rst           = 1'b1;
    req_valid_i   = 1'b0;
    req_core_i    = 2'd0;
    unit_valid_i  = 1'b0;
    unit_result_i = '0;
    unit_flags_i  = '0;
    core_ready_i  = 4'b0000;
    fix_res       = '0;
    fix_fl        = '0;

    // Reset held two cycles, then ready must come up immediately.
    run(2);
    rst = 1'b0;
    run(1);
    chk("reset_result_zero", 64'(core_result_o), 64'd0);

    // Single op for core 2 with known data.
    req_valid_i = 1'b1;
    req_core_i  = 2'd2;
    fix_en      = 1'b1;
    fix_res     = 32'h3F80_0000;
    fix_fl      = 5'b00001;
    core_ready_i = 4'b0100;
    run(1);
    fix_en      = 1'b0;
    req_valid_i = 1'b0;
    run(4);

    // Backpressure with head-of-line blocking.
    core_ready_i = 4'b0000;
    req_valid_i  = 1'b1;
    req_core_i   = 2'd1;
    run(1);
    req_core_i   = 2'd3;
    run(1);
    req_core_i   = 2'd1;
    run(3);
    req_valid_i  = 1'b0;
    core_ready_i = 4'b1000;
    run(3);
    chk("hol_blocked", 64'(ndelivered), 64'd1);
    core_ready_i = 4'b1010;
    run(5);
    chk("hol_drained", 64'(ndelivered), 64'd4);

    // Full-rate streaming, all cores ready.
    core_ready_i = 4'b1111;
    base = ndelivered;
    for (int i = 0; i < 8; i++) begin
      req_valid_i = 1'b1;
      req_core_i  = 2'(i);
      run(1);
    end
    req_valid_i = 1'b0;
    run(2);
    chk("stream_count", 64'(ndelivered - base), 64'd8);
    run(2);

    // Unit result with no outstanding tag.
    inject = 1'b1;
    run(1);
    inject = 1'b0;
    run(3);
    chk("err_sticky", 64'(err_o), 64'd1);

    // Reset with work in flight and buffered.
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    core_ready_i = 4'b0000;
    req_valid_i  = 1'b1;
    req_core_i   = 2'($urandom);
    run(3);
    req_valid_i  = 1'b0;
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    core_ready_i = 4'b1111;
    run(4);
    inject = 1'b1;
    run(1);
    inject = 1'b0;
    run(2);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      req_valid_i  = ($urandom_range(0, 3) != 0);
      req_core_i   = 2'($urandom);
      core_ready_i = ($urandom_range(0, 4) == 0) ? 4'b1111 : 4'($urandom);
      run(1);
    end
    req_valid_i  = 1'b0;
    core_ready_i = 4'b1111;
    run(6);
    chk("final_drain_empty", 64'(core_valid_o), 64'd0);

    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(2);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
